// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit
//   In-order tracker for conditional branches predicted in fetch. Each entry
//   holds {pc, predicted direction, predicted target}. When execute resolves
//   the oldest branch, the outcome is compared with the stored prediction and
//   a registered flush/redirect plus a one-cycle BHT update command is issued.
//   A mispredict discards every younger (wrong-path) entry on the same edge.
//
//   Optional feature: define BRU_STATS_EN to build the saturating 16-bit
//   resolved/mispredict counters; otherwise both stat ports are tied to 0.
//
//   The head entry is read combinationally so the resolve comparison happens
//   in the same cycle the resolve arrives; the storage is therefore small
//   distributed memory rather than a registered-read block RAM.
//   The update index is the low 6 bits of the branch PC (PC_W >= 6 expected;
//   narrower PCs are zero-extended).

module branch_resolution_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [PC_W-1:0]          push_pc,
  input  logic                     push_pred,
  input  logic [PC_W-1:0]          push_target,
  input  logic                     resolve,
  input  logic                     resolve_taken,
  input  logic [PC_W-1:0]          resolve_target,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     flush,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     upd_valid,
  output logic [5:0]               upd_index,
  output logic                     upd_taken,
  output logic                     err_overflow,
  output logic                     err_underflow,
  output logic [15:0]              stat_resolved,
  output logic [15:0]              stat_mispred
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry storage (no reset: contents are meaningless once pointers clear)
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic            pred_mem [DEPTH];
  logic [PC_W-1:0] tgt_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic            flush_q;
  logic [PC_W-1:0] redirect_pc_q;
  logic            upd_valid_q;
  logic [5:0]      upd_index_q;
  logic            upd_taken_q;
  logic            err_overflow_q;
  logic            err_underflow_q;

  logic            is_full;
  logic            is_empty;
  logic            do_resolve;
  logic            underflow_evt;
  logic            overflow_evt;
  logic            push_ok;
  logic            mis;
  logic [PC_W-1:0] head_pc;
  logic            head_pred;
  logic [PC_W-1:0] head_tgt;
  logic [5:0]      head_idx;
  logic [PC_W-1:0] redirect_d;

  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);

  assign head_pc   = pc_mem[rd_ptr_q];
  assign head_pred = pred_mem[rd_ptr_q];
  assign head_tgt  = tgt_mem[rd_ptr_q];

  // Update index is the low six PC bits; zero-extend if the PC is narrower.
  generate
    if (PC_W >= 6) begin : g_idx_slice
      assign head_idx = head_pc[5:0];
    end else begin : g_idx_ext
      assign head_idx = {{(6-PC_W){1'b0}}, head_pc};
    end
  endgenerate

  // A resolve only counts when there is a branch to resolve; there is no
  // bypass from a same-cycle push into an empty queue.
  assign do_resolve    = resolve & ~is_empty;
  assign underflow_evt = resolve &  is_empty;

  // Wrong direction, or right "taken" direction with a wrong target.
  assign mis = do_resolve &
               ((resolve_taken != head_pred) |
                (resolve_taken & head_pred & (resolve_target != head_tgt)));

  // A push fits if there is room or the head retires this cycle; a mispredict
  // discards it as wrong-path without counting as an overflow.
  assign push_ok      = push & (~is_full | do_resolve) & ~mis;
  assign overflow_evt = push & is_full & ~do_resolve;

  // Not-taken redirect is the fall-through PC, wrapping at 2^PC_W.
  assign redirect_d = resolve_taken ? resolve_target : (head_pc + PC_W'(1));

  // Next pointer/count state; a mispredict empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mis) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok)    wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_resolve) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, do_resolve})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Write an accepted branch into the tail slot.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr_q]   <= push_pc;
      pred_mem[wr_ptr_q] <= push_pred;
      tgt_mem[wr_ptr_q]  <= push_target;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Registered resolve results: single-cycle pulses, held payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_q       <= 1'b0;
      upd_valid_q   <= 1'b0;
      redirect_pc_q <= '0;
      upd_index_q   <= '0;
      upd_taken_q   <= 1'b0;
    end else begin
      flush_q     <= mis;
      upd_valid_q <= do_resolve;
      if (do_resolve) begin
        redirect_pc_q <= redirect_d;
        upd_index_q   <= head_idx;
        upd_taken_q   <= resolve_taken;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      if (overflow_evt)  err_overflow_q  <= 1'b1;
      if (underflow_evt) err_underflow_q <= 1'b1;
    end
  end

`ifdef BRU_STATS_EN
  logic [15:0] stat_resolved_q;
  logic [15:0] stat_mispred_q;

  // Saturating resolve/mispredict counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      if (do_resolve && (stat_resolved_q != 16'hFFFF))
        stat_resolved_q <= stat_resolved_q + 16'd1;
      if (mis && (stat_mispred_q != 16'hFFFF))
        stat_mispred_q <= stat_mispred_q + 16'd1;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`else
  assign stat_resolved = 16'h0000;
  assign stat_mispred  = 16'h0000;
`endif

  assign full          = is_full;
  assign empty         = is_empty;
  assign count         = count_q;
  assign flush         = flush_q;
  assign redirect_pc   = redirect_pc_q;
  assign upd_valid     = upd_valid_q;
  assign upd_index     = upd_index_q;
  assign upd_taken     = upd_taken_q;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

endmodule
